// File: rtl/div_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_pkg
//  Description : Shared types, opcodes and helpers for the divider issue
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

    // Shared divide/remainder opcode encoding used by issue
    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_REM   = 3'd2;
    localparam logic [2:0] OP_REMU  = 3'd3;
    localparam logic [2:0] OP_DIVW  = 3'd4;
    localparam logic [2:0] OP_DIVUW = 3'd5;
    localparam logic [2:0] OP_REMW  = 3'd6;
    localparam logic [2:0] OP_REMUW = 3'd7;

    // 32-bit architectural special-case constants
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FAST  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    function automatic logic is_signed(input logic [2:0] sel);
        return (sel == OP_DIV) || (sel == OP_REM) ||
               (sel == OP_DIVW) || (sel == OP_REMW);
    endfunction

    function automatic logic is_rem(input logic [2:0] sel);
        return (sel == OP_REM) || (sel == OP_REMU) ||
               (sel == OP_REMW) || (sel == OP_REMUW);
    endfunction

    function automatic logic is_word(input logic [2:0] sel);
        return (sel == OP_DIVW) || (sel == OP_DIVUW) ||
               (sel == OP_REMW) || (sel == OP_REMUW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_ctrl_if
//  Description : Request, divider and writeback signals of the divider
//                issue sequencer. slave = controller view, master = the
//                surrounding pipeline (issue, divider, writeback).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_issue_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int DW    = 64,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_op1;
    logic [XLEN-1:0]  req_op2;
    logic [2:0]       req_select;
    logic [TAG_W-1:0] req_tag;

    logic             div_start;
    logic [DW-1:0]    div_inp1;
    logic [DW-1:0]    div_inp2;
    logic             div_ready;
    logic [DW-1:0]    div_quo;
    logic [DW-1:0]    div_rem;

    logic             resp_valid;
    logic             resp_ready;
    logic [TAG_W-1:0] resp_tag;
    logic [XLEN-1:0]  resp_result;

    modport slave (
        input  req_valid, req_op1, req_op2, req_select, req_tag,
        output req_ready,
        output div_start, div_inp1, div_inp2,
        input  div_ready, div_quo, div_rem,
        output resp_valid, resp_tag, resp_result,
        input  resp_ready
    );

    modport master (
        output req_valid, req_op1, req_op2, req_select, req_tag,
        input  req_ready,
        input  div_start, div_inp1, div_inp2,
        output div_ready, div_quo, div_rem,
        input  resp_valid, resp_tag, resp_result,
        output resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl_special_case.sv
`default_nettype none
// ============================================================================
//  Module      : div_special_case
//  Description : Detects divide-by-zero and signed overflow and produces the
//                architecturally defined result for them.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_special_case
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] op1,
    input  wire logic [XLEN-1:0] op2,
    input  wire logic [2:0]      select,
    output logic                 is_special,
    output logic [XLEN-1:0]      special_result
);

    localparam logic [XLEN-1:0] c_xlen_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_word;
    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN-1:0] w_op1_res;

    // Word ops return their 32-bit result sign-extended to XLEN
    generate
        if (XLEN > 32) begin : g_wide
            assign w_op1_res = w_word ? {{(XLEN-32){op1[31]}}, op1[31:0]} : op1;
        end else begin : g_narrow
            assign w_op1_res = op1;
        end
    endgenerate

    // Classify the operands and pick the locally resolved result
    always_comb begin
        w_word     = is_word(select);
        w_div_zero = w_word ? (op2[31:0] == 32'd0) : (op2 == '0);
        w_overflow = is_signed(select) &&
                     (w_word ? ((op1[31:0] == INT_MIN) && (op2[31:0] == NEG_ONE))
                             : ((op1 == c_xlen_int_min) && (op2 == '1)));
        is_special = w_div_zero || w_overflow;
        special_result = '0;
        if (w_div_zero) begin
            special_result = is_rem(select) ? w_op1_res : '1;
        end else if (w_overflow) begin
            special_result = is_rem(select) ? '0 : w_op1_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_ctrl
//  Description : Sequences one divide/remainder request at a time into the
//                multi-cycle divider, resolving div-by-zero and signed
//                overflow locally, and returns a tagged result to writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DW    = 64,
    parameter int TAG_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       flush,
    output logic            busy,
    div_issue_ctrl_if.slave bus
);

    state_t          r_state;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [2:0]      r_sel;

    logic [XLEN-1:0] w_sc_op1;
    logic [XLEN-1:0] w_sc_op2;
    logic [2:0]      w_sc_sel;
    logic            w_is_special;
    logic [XLEN-1:0] w_special_result;
    logic            w_accept;
    logic            w_sext;
    logic [DW-1:0]   w_ext1;
    logic [DW-1:0]   w_ext2;
    logic [XLEN-1:0] w_div_result;
    logic            w_unused_bits;

    // In IDLE the special-case check looks at the incoming request so the
    // FAST/START decision can be made at accept; afterwards it sees the
    // latched operands so FAST produces the result from stable values.
    always_comb begin
        w_sc_op1 = (r_state == IDLE) ? bus.req_op1    : r_op1;
        w_sc_op2 = (r_state == IDLE) ? bus.req_op2    : r_op2;
        w_sc_sel = (r_state == IDLE) ? bus.req_select : r_sel;
    end

    div_special_case #(.XLEN(XLEN)) u_special (
        .op1            (w_sc_op1),
        .op2            (w_sc_op2),
        .select         (w_sc_sel),
        .is_special     (w_is_special),
        .special_result (w_special_result)
    );

    // Operand extension to divider width and result selection
    always_comb begin
        w_accept = bus.req_valid && bus.req_ready && !flush;
        w_sext   = is_signed(bus.req_select);
        if (is_word(bus.req_select)) begin
            w_ext1 = {{(DW-32){w_sext & bus.req_op1[31]}}, bus.req_op1[31:0]};
            w_ext2 = {{(DW-32){w_sext & bus.req_op2[31]}}, bus.req_op2[31:0]};
        end else begin
            w_ext1 = {{(DW-XLEN){w_sext & bus.req_op1[XLEN-1]}}, bus.req_op1};
            w_ext2 = {{(DW-XLEN){w_sext & bus.req_op2[XLEN-1]}}, bus.req_op2};
        end
        w_div_result  = is_rem(r_sel) ? bus.div_rem[XLEN-1:0] : bus.div_quo[XLEN-1:0];
        w_unused_bits = ^{bus.div_quo[DW-1:XLEN], bus.div_rem[DW-1:XLEN]};
    end

    // Sequencer FSM; every output is registered and set on the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_op1           <= '0;
            r_op2           <= '0;
            r_sel           <= '0;
            bus.req_ready   <= 1'b1;
            bus.div_start   <= 1'b0;
            bus.div_inp1    <= '0;
            bus.div_inp2    <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_tag    <= '0;
            bus.resp_result <= '0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op1         <= bus.req_op1;
                        r_op2         <= bus.req_op2;
                        r_sel         <= bus.req_select;
                        bus.resp_tag  <= bus.req_tag;
                        bus.div_inp1  <= w_ext1;
                        bus.div_inp2  <= w_ext2;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (w_is_special) begin
                            r_state <= FAST;
                        end else begin
                            r_state       <= START;
                            bus.div_start <= 1'b1;
                        end
                    end
                end
                FAST: begin
                    if (flush) begin
                        r_state       <= IDLE;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        r_state         <= HOLD;
                        bus.resp_result <= w_special_result;
                        bus.resp_valid  <= 1'b1;
                    end
                end
                START: begin
                    // The start pulse has already gone out, so a flush here
                    // must still drain the divider's result.
                    bus.div_start <= 1'b0;
                    r_state       <= flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (bus.div_ready) begin
                        if (flush) begin
                            r_state       <= IDLE;
                            bus.req_ready <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            r_state         <= HOLD;
                            bus.resp_result <= w_div_result;
                            bus.resp_valid  <= 1'b1;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (flush || bus.resp_ready) begin
                        r_state        <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.div_ready) begin
                        r_state       <= IDLE;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.div_start  <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_issue_ctrl
//  Description : Self-checking bench for div_issue_ctrl with a behavioural
//                divider and a RISC-V division reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;
    import div_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    div_issue_ctrl_if #(.XLEN(32), .DW(64), .TAG_W(4)) bus ();

    div_issue_ctrl #(.XLEN(32), .DW(64), .TAG_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit op_signed(input logic [2:0] sel);
        return sel inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic bit op_rem(input logic [2:0] sel);
        return sel inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic [63:0] ext64(input logic [31:0] v, input bit s);
        return s ? {{32{v[31]}}, v} : {32'd0, v};
    endfunction

    function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
        return (b == 0) || (op_signed(sel) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension result rules on 32-bit values
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
        int sa, sb;
        if (b == 0) return op_rem(sel) ? a : 32'hFFFF_FFFF;
        if (op_signed(sel)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op_rem(sel) ? 32'd0 : a;
            sa = a;
            sb = b;
            return op_rem(sel) ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op_rem(sel) ? a % b : a / b;
    endfunction

    // Present one request for a cycle; returns at the negedge after accept
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel, input logic [3:0] tag);
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_op1    = a;
        bus.req_op2    = b;
        bus.req_select = sel;
        bus.req_tag    = tag;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    // Pulse div_ready with the behavioural divider output for given operands
    task automatic divider_reply(input logic [63:0] e1, input logic [63:0] e2);
        logic signed [63:0] s1, s2;
        s1 = e1;
        s2 = e2;
        bus.div_ready = 1'b1;
        bus.div_quo   = s1 / s2;
        bus.div_rem   = s1 % s2;
        @(negedge clk);
        bus.div_ready = 1'b0;
        bus.div_quo   = '0;
        bus.div_rem   = '0;
    endtask

    // Complete transaction: accept, divide or fast path, hold, retire
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                          input logic [3:0] tag, input int div_dly, input int hold_dly);
        logic [63:0] e1, e2;
        logic [31:0] exp;
        e1  = ext64(a, op_signed(sel));
        e2  = ext64(b, op_signed(sel));
        exp = ref_result(a, b, sel);
        issue(a, b, sel, tag);
        check("busy_after_accept", busy, 1);
        check("req_ready_low", bus.req_ready, 0);
        if (ref_special(a, b, sel)) begin
            check("fast_no_start", bus.div_start, 0);
            check("fast_no_early_valid", bus.resp_valid, 0);
            @(negedge clk);
            check("fast_no_start2", bus.div_start, 0);
            check("fast_valid_n2", bus.resp_valid, 1);
        end else begin
            check("div_start", bus.div_start, 1);
            check("div_inp1", bus.div_inp1, e1);
            check("div_inp2", bus.div_inp2, e2);
            for (int i = 0; i <= div_dly; i++) begin
                @(negedge clk);
                check("start_one_cycle", bus.div_start, 0);
                check("no_early_valid", bus.resp_valid, 0);
                check("inp1_stable", bus.div_inp1, e1);
            end
            divider_reply(e1, e2);
            check("resp_valid", bus.resp_valid, 1);
        end
        check("resp_result", bus.resp_result, exp);
        check("resp_tag", bus.resp_tag, tag);
        // Offer a competing request while the result is held
        bus.req_valid  = 1'b1;
        bus.req_op1    = $urandom;
        bus.req_op2    = $urandom;
        bus.req_select = 3'($urandom);
        bus.req_tag    = 4'($urandom);
        for (int i = 0; i < hold_dly; i++) begin
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1);
            check("hold_result", bus.resp_result, exp);
            check("hold_tag", bus.resp_tag, tag);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        check("retire_valid", bus.resp_valid, 0);
        check("retire_req_ready", bus.req_ready, 1);
        check("retire_not_busy", busy, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        bus.req_select = '0;
        bus.req_tag = '0;
        bus.div_ready = 1'b0;
        bus.div_quo = '0;
        bus.div_rem = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", bus.req_ready, 1);
        check("rst_div_start", bus.div_start, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_inp1", bus.div_inp1, 0);
        check("rst_inp2", bus.div_inp2, 0);
        check("rst_tag", bus.resp_tag, 0);
        check("rst_result", bus.resp_result, 0);

        // Directed cases
        run_op(32'd100, 32'd7, OP_DIVU, 4'd3, 2, 0);
        run_op(32'hFFFF_FFF9, 32'd2, OP_REM, 4'd5, 1, 1);
        run_op(32'd5, 32'd0, OP_DIV, 4'd6, 0, 0);
        run_op(32'd5, 32'd0, OP_REMU, 4'd7, 0, 2);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 4'd8, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_REM, 4'd9, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIVU, 4'd10, 1, 0);
        run_op(32'hFFFF_FF00, 32'd16, OP_DIVW, 4'd11, 0, 5);

        // Flush two cycles into WAIT: drain until div_ready
        issue(32'd1000, 32'd9, OP_DIV, 4'd1);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_req_ready", bus.req_ready, 0);
            check("drain_no_valid", bus.resp_valid, 0);
            check("drain_busy", busy, 1);
            @(negedge clk);
        end
        divider_reply(ext64(32'd1000, 1), ext64(32'd9, 1));
        check("drain_done_ready", bus.req_ready, 1);
        check("drain_done_valid", bus.resp_valid, 0);
        run_op(32'd77, 32'd8, OP_REMU, 4'd2, 1, 0);

        // Flush in WAIT coinciding with div_ready returns straight to IDLE
        issue(32'd50, 32'd5, OP_DIVU, 4'd4);
        @(negedge clk);
        flush = 1'b1;
        divider_reply(64'd50, 64'd5);
        flush = 1'b0;
        check("flush_rdy_same_ready", bus.req_ready, 1);
        check("flush_rdy_same_valid", bus.resp_valid, 0);

        // Flush during START: start still issued, then drain
        issue(32'd60, 32'd6, OP_DIVU, 4'd12);
        check("start_flush_pulse", bus.div_start, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("start_flush_drain", bus.req_ready, 0);
        check("start_flush_nostart", bus.div_start, 0);
        @(negedge clk);
        divider_reply(64'd60, 64'd6);
        check("start_flush_idle", bus.req_ready, 1);
        check("start_flush_novalid", bus.resp_valid, 0);

        // Flush during FAST drops the response
        issue(32'd9, 32'd0, OP_DIV, 4'd13);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fast_flush_valid", bus.resp_valid, 0);
        check("fast_flush_ready", bus.req_ready, 1);

        // Flush during HOLD drops the response
        issue(32'd9, 32'd0, OP_REM, 4'd14);
        @(negedge clk);
        check("hold_flush_pre", bus.resp_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("hold_flush_valid", bus.resp_valid, 0);
        check("hold_flush_ready", bus.req_ready, 1);

        // Flush in IDLE blocks the accept; stray div_ready is ignored
        bus.req_valid = 1'b1;
        bus.req_op1 = 32'd4;
        bus.req_op2 = 32'd2;
        bus.req_select = OP_DIVU;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.req_valid = 1'b0;
        check("idle_flush_busy", busy, 0);
        check("idle_flush_nostart", bus.div_start, 0);
        divider_reply(64'd1, 64'd1);
        check("stray_ready_valid", bus.resp_valid, 0);
        check("stray_ready_busy", busy, 0);

        // Reset in the middle of WAIT
        issue(32'd30, 32'd3, OP_DIVU, 4'd15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_tag", bus.resp_tag, 0);
        run_op(32'd30, 32'd3, OP_DIVU, 4'd15, 0, 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(a, b, 3'($urandom_range(0, 7)), 4'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencer in front of the stage3 multi-cycle integer divider. It accepts one divide/remainder request at a time from issue over a valid/ready handshake and prepares sign- or zero-extended operands. It pulses start to the divider, waits for completion, selects quotient or remainder, and presents a tagged result to writeback. Divide-by-zero and signed-overflow cases are resolved locally in one cycle without starting the divider, with RISC-V-mandated results.

Parameters:
XLEN, 32, architectural operand/result width
DW, 64, divider operand width (extension target)
TAG_W, 4, width of request/result tag (ROB/writeback id)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill any in-flight or pending operation
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_op1  in  XLEN  dividend
req_op2  in  XLEN  divisor
req_select  in  3  op code (shared DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW constants)
req_tag  in  TAG_W  request tag
div_start  out  1  one-cycle start pulse to divider
div_inp1  out  DW  extended dividend
div_inp2  out  DW  extended divisor
div_ready  in  1  divider result valid (one-cycle pulse)
div_quo  in  DW  quotient
div_rem  in  DW  remainder
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts
resp_tag  out  TAG_W  tag of result
resp_result  out  XLEN  quotient or remainder, low XLEN bits
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. req_ready=1 after reset. div_start, resp_valid and busy are 0. div_inp1/2, resp_tag and resp_result are 0.
- Accept: req_valid & req_ready & ~flush at a posedge latches op1, op2, select and tag. req_ready=1 only in IDLE.
- Extension:
  - Signed ops (DIV, REM, DIVW, REMW): sign-extend to DW.
  - Unsigned ops: zero-extend.
  - W variants extend op[31:0].
  - div_inp1/2 are registered and held stable from START through WAIT.
- States:
  - IDLE: on accept, go to FAST if divisor==0 or (signed & op1==0x8000_0000 & op2==0xFFFF_FFFF). Otherwise go to START.
  - FAST: compute the result and go to HOLD (resp_valid asserted the cycle after FAST).
    - Divisor 0: quotient = all ones; remainder = op1.
    - Signed overflow: quotient = op1 (0x8000_0000); remainder = 0.
  - START: div_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: on div_ready, capture div_quo[XLEN-1:0] for DIV* ops or div_rem[XLEN-1:0] for REM* ops into resp_result, then go to HOLD.
  - HOLD: resp_valid=1 with resp_tag and resp_result stable. On resp_ready, go to IDLE; req_ready rises the next cycle (no same-cycle back-to-back).
  - DRAIN: reached on flush during START or WAIT. Wait for div_ready, discard the result, go to IDLE. req_ready=0 throughout.
- Latency:
  - Fast path: accept at cycle N, resp_valid at N+2.
  - Normal path: div_start at N+1; resp_valid the cycle after div_ready.
- Flush:
  - IDLE: accept blocked that cycle.
  - FAST or HOLD: go to IDLE and drop the response; resp_valid is 0 the next cycle.
  - START: go to DRAIN. div_start is still issued this cycle, so the divider's pending result is drained.
  - WAIT: go to DRAIN. If div_ready arrives in the same cycle as flush, go directly to IDLE.
- div_ready outside WAIT/DRAIN: ignored.
- rst mid-operation: immediate return to IDLE. The divider shares rst, so no drain is needed.

Decomposition:
- Package div_ctrl_pkg holds:
  - state enum {IDLE, FAST, START, WAIT, HOLD, DRAIN};
  - helper functions is_signed(select), is_rem(select), is_word(select);
  - constants DIV_ZERO_QUO, INT_MIN, NEG_ONE.
- Opcode constants come from the existing shared op definitions.
- One natural sub-module: div_special_case, combinational. Inputs: op1, op2, select. Outputs: is_special, special_result.

Test Plan:
- DIVU 100/7, tag 3 -> div_start one cycle after accept, inp1=100, inp2=7. After div_ready: resp_result=14, resp_tag=3.
- REM 0xFFFF_FFF9 (-7) / 2 -> inp1=0xFFFF_FFFF_FFFF_FFF9. Result 0xFFFF_FFFF (-1).
- DIV 5/0 -> no div_start, resp_result=0xFFFF_FFFF at N+2. REMU 5/0 -> 5.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> no div_start, result 0x8000_0000. REM of the same operands -> 0.
- Flush two cycles into WAIT -> req_ready stays 0 until div_ready. No resp_valid. The next request's result is correct.
- resp_ready held low 5 cycles in HOLD -> resp_valid, result and tag stable. req_valid is not accepted until one cycle after resp_ready.
